// File: rtl/module_byte_packer.sv
// RX byte-to-word packer: aligns on a run of idle COM characters, then packs
// valid bytes MSB-first into 32-bit words with a one-cycle valid pulse.
module module_byte_packer #(
  parameter logic [7:0] COM_CHAR   = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic        clk_Packer,
  input  logic        reset_L,
  input  logic        valid_in_Packer,
  input  logic [7:0]  data_in_Packer,
  output logic        valid_out_Packer,
  output logic [31:0] data_out_Packer,
  output logic        active_Packer
);

  localparam int CW = $clog2(SYNC_COUNT + 1);
  localparam logic [CW-1:0] SYNC_MAX  = CW'(SYNC_COUNT);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_COUNT - 1);

  typedef enum logic {SEARCH, ACTIVE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_com_cnt;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_partial;
  logic          r_valid_out;
  logic [31:0]   r_data_out;
  logic          r_active;
  logic          w_idle_com;

  assign w_idle_com = !valid_in_Packer && (data_in_Packer == COM_CHAR);

  always_ff @(posedge clk_Packer or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= SEARCH;
      r_com_cnt   <= '0;
      r_byte_cnt  <= 2'd0;
      r_partial   <= 24'h0;
      r_valid_out <= 1'b0;
      r_data_out  <= 32'h0;
      r_active    <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        SEARCH: begin
          // Valid bytes seen while searching are dropped and break the COM run.
          if (w_idle_com) begin
            if (r_com_cnt != SYNC_MAX) r_com_cnt <= r_com_cnt + CW'(1);
            if (r_com_cnt == SYNC_LAST) begin
              r_state    <= ACTIVE;
              r_active   <= 1'b1;
              r_byte_cnt <= 2'd0;
            end
          end else begin
            r_com_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (valid_in_Packer) begin
            case (r_byte_cnt)
              2'd0: r_partial[23:16] <= data_in_Packer;
              2'd1: r_partial[15:8]  <= data_in_Packer;
              2'd2: r_partial[7:0]   <= data_in_Packer;
              default: begin
                r_data_out  <= {r_partial, data_in_Packer};
                r_valid_out <= 1'b1;
              end
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign valid_out_Packer = r_valid_out;
  assign data_out_Packer  = r_data_out;
  assign active_Packer    = r_active;

endmodule

// File: tb/tb_module_byte_packer.sv
// Bench for module_byte_packer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_module_byte_packer;

  localparam logic [7:0] COM = 8'hBC;
  localparam int SYNC = 4;

  logic        clk_Packer = 1'b0;
  logic        reset_L;
  logic        valid_in_Packer;
  logic [7:0]  data_in_Packer;
  logic        valid_out_Packer;
  logic [31:0] data_out_Packer;
  logic        active_Packer;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_aligned;
  int          m_com_run;
  logic [7:0]  m_bytes[$];
  logic        exp_valid;
  logic [31:0] exp_data;
  logic        exp_active;

  module_byte_packer #(.COM_CHAR(COM), .SYNC_COUNT(SYNC)) dut (
    .clk_Packer       (clk_Packer),
    .reset_L          (reset_L),
    .valid_in_Packer  (valid_in_Packer),
    .data_in_Packer   (data_in_Packer),
    .valid_out_Packer (valid_out_Packer),
    .data_out_Packer  (data_out_Packer),
    .active_Packer    (active_Packer)
  );

  always #5 clk_Packer = ~clk_Packer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".valid"},  {31'd0, valid_out_Packer}, {31'd0, exp_valid});
    check({where, ".data"},   data_out_Packer, exp_data);
    check({where, ".active"}, {31'd0, active_Packer}, {31'd0, exp_active});
  endtask

  task automatic model_reset();
    m_aligned  = 0;
    m_com_run  = 0;
    m_bytes.delete();
    exp_valid  = 1'b0;
    exp_data   = 32'h0;
    exp_active = 1'b0;
  endtask

  // Behaviour after one clock edge sampling (v, d).
  task automatic model_edge(input logic v, input logic [7:0] d);
    exp_valid = 1'b0;
    if (!m_aligned) begin
      if (!v && d == COM) begin
        m_com_run++;
        if (m_com_run >= SYNC) m_aligned = 1;
      end else begin
        m_com_run = 0;
      end
    end else if (v) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 4) begin
        exp_data  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        exp_valid = 1'b1;
        m_bytes.delete();
      end
    end
    exp_active = m_aligned;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk_Packer);
    valid_in_Packer = v;
    data_in_Packer  = d;
    @(posedge clk_Packer);
    model_edge(v, d);
    #1;
    $display("step v=%0b d=%h -> valid=%0b data=%h active=%0b", v, d,
             valid_out_Packer, data_out_Packer, active_Packer);
    check_all("step");
  endtask

  // Reset asserted between edges must clear outputs with no clock.
  task automatic mid_reset();
    @(negedge clk_Packer);
    valid_in_Packer = 1'b0;
    data_in_Packer  = 8'h00;
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    $display("async reset -> valid=%0b data=%h active=%0b",
             valid_out_Packer, data_out_Packer, active_Packer);
    check_all("async_reset");
    @(negedge clk_Packer);
    reset_L = 1'b1;
  endtask

  task automatic align();
    for (int i = 0; i < SYNC; i++) step(1'b0, COM);
  endtask

  initial begin
    reset_L         = 1'b0;
    valid_in_Packer = 1'b0;
    data_in_Packer  = 8'h00;
    model_reset();
    #3;
    check_all("reset_state");
    @(negedge clk_Packer);
    reset_L = 1'b1;

    // Alignment with a broken run and a payload byte that must be dropped
    step(1'b1, 8'h55);
    for (int i = 0; i < 3; i++) step(1'b0, COM);
    step(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, COM);
    check("aligned_after_8", {31'd0, active_Packer}, 32'd1);

    // Basic packing
    step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, 8'h33); step(1'b1, 8'h44);
    check("word_11223344", data_out_Packer, 32'h11223344);
    step(1'b0, 8'h00);

    // Gaps, including COM idle in ACTIVE
    step(1'b1, 8'hAA); step(1'b0, COM); step(1'b1, 8'hBB); step(1'b1, 8'hCC);
    step(1'b0, 8'h00); step(1'b0, COM); step(1'b1, 8'hDD);
    check("word_AABBCCDD", data_out_Packer, 32'hAABBCCDD);
    step(1'b0, 8'h00); step(1'b0, 8'h00);

    // Payload COM and back-to-back words
    step(1'b1, 8'hBC);
    for (int i = 1; i < 8; i++) step(1'b1, 8'(i));
    check("word_04050607", data_out_Packer, 32'h04050607);

    // Reset mid-word, bytes before realignment are dropped
    step(1'b1, 8'h99); step(1'b1, 8'h88);
    mid_reset();
    step(1'b1, 8'h01); step(1'b1, 8'h02);
    align();
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i));
    check("word_01020304", data_out_Packer, 32'h01020304);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      logic       v;
      logic [7:0] d;
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        v = 1'($urandom_range(0, 1));
        d = ($urandom_range(0, 2) == 0) ? COM : 8'($urandom);
        step(v, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/module_byte_packer.md
# module_byte_packer

Receive-side byte-to-word packer for the PHY RX path. It accepts the recovered 8-bit byte stream with its valid flag, and achieves lane alignment by counting consecutive idle COM characters. It then packs valid bytes MSB-first into 32-bit words and presents each completed word with a one-cycle valid pulse to the 32-bit register stage that follows it.

## Interface
- COM_CHAR, 8'hBC, idle/comma character used for alignment (only counted when valid is low)
- SYNC_COUNT, 4, number of consecutive COM idle bytes required to declare alignment (≥1)
- clk_Packer  input  1  byte clock; all state updates on rising edge
- reset_L  input  1  asynchronous, active-low reset
- valid_in_Packer  input  1  byte on data_in_Packer is payload when 1, idle when 0
- data_in_Packer  input  8  received byte
- valid_out_Packer  output  1  one-cycle pulse: data_out_Packer holds a newly completed word
- data_out_Packer  output  32  last completed word, {byte0,byte1,byte2,byte3}
- active_Packer  output  1  alignment achieved; packing enabled

## Operation
- One clock; reset is asynchronous and active-low. reset_L=0 immediately forces state SEARCH, com counter 0, byte counter 0, partial word 0, valid_out_Packer=0, data_out_Packer=32'h0, active_Packer=0.
- FSM states: SEARCH, ACTIVE. No other transitions; ACTIVE is left only via reset.
- SEARCH:
  - cycle with valid_in_Packer=0 and data_in_Packer==COM_CHAR increments com counter (saturating, width clog2(SYNC_COUNT+1));
  - any other cycle (valid byte, or idle non-COM byte) clears com counter to 0;
  - the edge that samples the SYNC_COUNT-th consecutive COM moves FSM to ACTIVE and sets active_Packer=1;
  - valid bytes in SEARCH are discarded; valid_out_Packer stays 0.
- ACTIVE:
  - valid bytes are packed MSB-first: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0]; 2-bit byte counter wraps 3->0;
  - on the 4th valid byte, data_out_Packer loads the full word (partial bytes plus current byte) and valid_out_Packer=1;
  - idle cycles (valid_in_Packer=0) hold byte counter and partial word, regardless of data value (COM in ACTIVE is ignored);
  - a COM_CHAR value with valid_in_Packer=1 is ordinary payload.
- data_out_Packer holds the last completed word between pulses (not cleared when valid_out_Packer is 0).
- Byte counter starts at 0 on entry to ACTIVE; bytes accepted in SEARCH never contribute.

## Timing
- All outputs registered; no combinational input-to-output path.
- Word latency: the 4th valid byte sampled at edge N yields data_out_Packer/valid_out_Packer=1 after edge N, deasserting after edge N+1 unless another word completes (impossible before N+4).
- Maximum output rate: one word per 4 clocks; valid_out_Packer is never high on two consecutive cycles.
- Alignment latency: active_Packer rises after the edge sampling the SYNC_COUNT-th consecutive idle COM; a valid byte on the very next cycle is byte 0 of the first word.
- Reset mid-word: the partial word is discarded, and after release the block must re-align (SYNC_COUNT COMs) before packing.
- Reset asserted asynchronously between edges clears outputs without waiting for a clock.

## Test plan
- Async reset: drive reset_L=0 mid-cycle during ACTIVE -> valid_out_Packer=0, data_out_Packer=32'h0, active_Packer=0 before the next edge.
- Alignment: 3 idle 0xBC, idle 0x00, then 4 idle 0xBC -> active_Packer=1 only after the 8th edge. A valid 0x55 sent during SEARCH never appears in any output word.
- Packing: after alignment, valid 0x11,0x22,0x33,0x44 on consecutive cycles -> data_out_Packer=32'h11223344 with a single-cycle valid_out_Packer after the 4th edge.
- Gaps: valid 0xAA, idle, valid 0xBB, 0xCC, idle, idle, valid 0xDD -> one pulse with 32'hAABBCCDD after the 0xDD edge. data_out_Packer holds 32'hAABBCCDD afterwards.
- Payload COM and back-to-back words: 8 consecutive valid bytes 0xBC,0x01,0x02,0x03,0x04,0x05,0x06,0x07 -> 32'hBC010203 then 32'h04050607, with pulses exactly 4 cycles apart.
- Reset mid-word: valid 0x99,0x88, then reset pulse, realign, then 0x01..0x04 -> output 32'h01020304 (no stale bytes).
